vga_timing: RTL

Generates the XGA 1024x768@60 raster timing that every drawing stage consumes. It is the producer end of `vga_if`: it drives `hcount`, `vcount`, `hsync`, `vsync`, `hblnk` and `vblnk` into the first stage of the draw pipeline, which then feeds `draw_game` and later stages. It also emits a one-cycle frame-start strobe for game-tick logic, such as bird and tube motion.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_if.sv | 14 +
 rtl/vga_axis_cnt.sv | 55 +++++
 rtl/vga_timing.sv | 80 ++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared XGA 1024x768@60 raster constants used by the timing generator and
// by every drawing stage that needs to agree on the visible area.
package vga_pkg;

    localparam int CNT_W   = 11;
    localparam int FRAME_W = 16;

    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // XGA uses negative-going sync pulses
    localparam logic XGA_SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/vga_if.sv
// Raster bundle passed down the draw pipeline: counters plus sync/blank.
interface vga_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping counter with registered blank/sync derived from
// the next count, so both line up with the count they describe.
module vga_axis_cnt #(
    parameter int   ACTIVE      = 1024,
    parameter int   FP          = 24,
    parameter int   SYNC        = 136,
    parameter int   BP          = 160,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    output logic [vga_pkg::CNT_W-1:0] count,
    output logic                     blnk,
    output logic                     sync,
    output logic                     wrap
);
    import vga_pkg::*;

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    if (TOTAL > (2 ** CNT_W) - 1) begin : g_width_check
        $error("vga_axis_cnt: ACTIVE+FP+SYNC+BP does not fit in the count width");
    end

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] BLNK_START = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] count_nxt;

    assign wrap = (count == LAST);

    always_comb begin
        count_nxt = count;
        if (en) begin
            count_nxt = wrap ? '0 : count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            blnk  <= 1'b0;
            sync  <= ~SYNC_ACTIVE;
        end else begin
            count <= count_nxt;
            blnk  <= (count_nxt >= BLNK_START);
            sync  <= ((count_nxt >= SYNC_START) && (count_nxt < SYNC_END)) ?
                     SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: horizontal and vertical axis counters, plus a
// frame-start strobe and frame counter for game-tick logic.
module vga_timing #(
    parameter int   H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int   H_FP        = vga_pkg::H_FP,
    parameter int   H_SYNC      = vga_pkg::H_SYNC,
    parameter int   H_BP        = vga_pkg::H_BP,
    parameter int   V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int   V_FP        = vga_pkg::V_FP,
    parameter int   V_SYNC      = vga_pkg::V_SYNC,
    parameter int   V_BP        = vga_pkg::V_BP,
    parameter logic SYNC_ACTIVE = vga_pkg::XGA_SYNC_ACTIVE
) (
    input  logic                        clk,
    input  logic                        rst,
    vga_if.out                          vout,
    output logic                        frame_start,
    output logic [vga_pkg::FRAME_W-1:0] frame_cnt
);
    import vga_pkg::*;

    logic             run_q;
    logic             h_wrap;
    logic             v_wrap;
    logic             frame_start_q;
    logic [FRAME_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;

    // Release is taken on the first edge after rst rises; that edge holds (0,0)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    vga_axis_cnt #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .SYNC_ACTIVE(SYNC_ACTIVE)
    ) u_h (
        .clk(clk), .rst_n(rst), .en(run_q),
        .count(hcount), .blnk(hblnk), .sync(hsync), .wrap(h_wrap)
    );

    vga_axis_cnt #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .SYNC_ACTIVE(SYNC_ACTIVE)
    ) u_v (
        .clk(clk), .rst_n(rst), .en(run_q & h_wrap),
        .count(vcount), .blnk(vblnk), .sync(vsync), .wrap(v_wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            frame_start_q <= run_q & h_wrap & v_wrap;
            if (run_q & h_wrap & v_wrap) begin
                frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
            end
        end
    end

    assign vout.hcount = hcount;
    assign vout.vcount = vcount;
    assign vout.hsync  = hsync;
    assign vout.vsync  = vsync;
    assign vout.hblnk  = hblnk;
    assign vout.vblnk  = vblnk;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
